sb_data_encoder: RTL and testbench

Sideband transmit-side message encoder. Accepts a message request from the link-training state machines (MsgCode, MsgSubCode, MsgInfo, optional 16-bit payload), builds the 64-bit sideband header and, when required, a 64-bit data beat. It presents both as beats to the sideband serializer over a valid/ready handshake. It is the transmit counterpart of the sideband data decoder: every field position and payload mapping here is the exact inverse of the receive-side extraction.

---
 rtl/sb_data_encoder_pkg.sv | 42 ++++
 rtl/sb_data_encoder_if.sv | 27 ++
 rtl/sb_data_encoder_packer.sv | 62 ++++++
 rtl/sb_data_encoder.sv | 117 +++++++++++
 tb/tb_sb_data_encoder.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/sb_data_encoder_pkg.sv
// Shared sideband definitions: opcodes, message codes, header field
// positions and the encoder FSM states. The receive-side decoder uses the
// same field positions, so the two stay exact inverses of each other.
package sb_pkg;

    // Header opcodes
    localparam logic [4:0] MSG_NO_DATA  = 5'b10010;
    localparam logic [4:0] MSG_64B_DATA = 5'b11011;

    // Message codes that may carry a data beat
    localparam logic [7:0] MSG_CODE_81 = 8'h81;
    localparam logic [7:0] MSG_CODE_85 = 8'h85;
    localparam logic [7:0] MSG_CODE_8A = 8'h8A;
    localparam logic [7:0] MSG_CODE_A5 = 8'hA5;
    localparam logic [7:0] MSG_CODE_AA = 8'hAA;

    // Fixed endpoint identifiers
    localparam logic [2:0] SRC_ID = 3'b001;
    localparam logic [2:0] DST_ID = 3'b101;

    // Header field bit positions
    localparam int HDR_OPC_LSB  = 0;
    localparam int HDR_CODE_LSB = 14;
    localparam int HDR_SRC_LSB  = 29;
    localparam int HDR_SUB_LSB  = 32;
    localparam int HDR_INFO_LSB = 40;
    localparam int HDR_DST_LSB  = 56;
    localparam int HDR_DP_BIT   = 62;
    localparam int HDR_CP_BIT   = 63;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } sb_state_e;

    // Even-parity helper shared by the DP and CP header bits
    function automatic logic parity64(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/sb_data_encoder_if.sv
// Request and beat handshake bundle between the link-training logic,
// the encoder and the sideband serializer.
interface sb_data_encoder_if;
    logic        i_msg_valid;
    logic        o_msg_ready;
    logic [7:0]  i_msgcode;
    logic [7:0]  i_msgsubcode;
    logic [15:0] i_msginfo;
    logic [15:0] i_data;
    logic [63:0] o_pkt;
    logic        o_pkt_valid;
    logic        i_pkt_ready;
    logic        o_header_is_valid_on_bus;
    logic        o_data_enable;

    // Encoder side
    modport slave (
        input  i_msg_valid, i_msgcode, i_msgsubcode, i_msginfo, i_data, i_pkt_ready,
        output o_msg_ready, o_pkt, o_pkt_valid, o_header_is_valid_on_bus, o_data_enable
    );

    // Requester / serializer side
    modport master (
        output i_msg_valid, i_msgcode, i_msgsubcode, i_msginfo, i_data, i_pkt_ready,
        input  o_msg_ready, o_pkt, o_pkt_valid, o_header_is_valid_on_bus, o_data_enable
    );
endinterface

// File: rtl/sb_data_encoder_packer.sv
// Combinational payload packer: decides whether a code/subcode pair carries
// a data beat and places the 16-bit payload at its wire positions.
module sb_data_packer
    import sb_pkg::*;
(
    input  logic [7:0]  code_i,
    input  logic [3:0]  sub_nib_i,
    input  logic [15:0] data_i,
    output logic [63:0] beat_o,
    output logic        has_data_o
);

    // Classify the message and scatter the payload bits
    always_comb begin
        beat_o     = 64'd0;
        has_data_o = 1'b0;
        case (code_i)
            MSG_CODE_85: begin
                if (sub_nib_i inside {4'h1, 4'h5, 4'h7, 4'hA}) begin
                    has_data_o  = 1'b1;
                    beat_o[0]   = data_i[0];
                    beat_o[7:6] = data_i[2:1];
                    beat_o[11]  = data_i[3];
                    beat_o[59]  = data_i[4];
                end else begin
                    has_data_o = 1'b0;
                end
            end
            MSG_CODE_81, MSG_CODE_8A: begin
                if (sub_nib_i inside {4'h3, 4'hB}) begin
                    has_data_o   = 1'b1;
                    beat_o[15:0] = data_i;
                end else begin
                    has_data_o = 1'b0;
                end
            end
            MSG_CODE_A5: begin
                if (sub_nib_i == 4'h0) begin
                    has_data_o   = 1'b1;
                    beat_o[10:0] = data_i[10:0];
                end else begin
                    has_data_o = 1'b0;
                end
            end
            MSG_CODE_AA: begin
                if (sub_nib_i == 4'h0) begin
                    has_data_o   = 1'b1;
                    beat_o[10:0] = data_i[10:0];
                end else if (sub_nib_i == 4'hF) begin
                    has_data_o   = 1'b1;
                    beat_o[15:0] = data_i;
                end else begin
                    has_data_o = 1'b0;
                end
            end
            default: begin
                has_data_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sb_data_encoder.sv
// Sideband transmit encoder: captures a message request, then presents the
// header beat and, for payload-carrying messages, one data beat to the
// serializer over a valid/ready handshake.
module sb_data_encoder
    import sb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    sb_data_encoder_if.slave  bus
);

    sb_state_e   state_q, state_d;
    logic [7:0]  code_q;
    logic [7:0]  sub_q;
    logic [15:0] info_q;
    logic [63:0] beat_q;
    logic        has_data_q;

    logic [63:0] beat_s;
    logic        has_data_s;
    logic        accept_s;
    logic [63:0] hdr_body_s;
    logic [63:0] hdr_s;

    sb_data_packer u_packer (
        .code_i     (bus.i_msgcode),
        .sub_nib_i  (bus.i_msgsubcode[3:0]),
        .data_i     (bus.i_data),
        .beat_o     (beat_s),
        .has_data_o (has_data_s)
    );

    assign accept_s = (state_q == ST_IDLE) && bus.i_msg_valid;

    // State register and request capture; reset discards any captured request
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            code_q     <= 8'd0;
            sub_q      <= 8'd0;
            info_q     <= 16'd0;
            beat_q     <= 64'd0;
            has_data_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept_s) begin
                code_q     <= bus.i_msgcode;
                sub_q      <= bus.i_msgsubcode;
                info_q     <= bus.i_msginfo;
                beat_q     <= beat_s;
                has_data_q <= has_data_s;
            end
        end
    end

    // Next-state logic: header always, data beat only when the message carries one
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_msg_valid) state_d = ST_HDR;
                else                 state_d = ST_IDLE;
            end
            ST_HDR: begin
                if (bus.i_pkt_ready) state_d = has_data_q ? ST_DATA : ST_IDLE;
                else                 state_d = ST_HDR;
            end
            ST_DATA: begin
                if (bus.i_pkt_ready) state_d = ST_IDLE;
                else                 state_d = ST_DATA;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Header assembly from the captured request; CP covers bits [61:0]
    always_comb begin
        hdr_body_s = 64'd0;
        hdr_body_s[HDR_OPC_LSB  +: 5]  = has_data_q ? MSG_64B_DATA : MSG_NO_DATA;
        hdr_body_s[HDR_CODE_LSB +: 8]  = code_q;
        hdr_body_s[HDR_SRC_LSB  +: 3]  = SRC_ID;
        hdr_body_s[HDR_SUB_LSB  +: 8]  = sub_q;
        hdr_body_s[HDR_INFO_LSB +: 16] = info_q;
        hdr_body_s[HDR_DST_LSB  +: 3]  = DST_ID;
        hdr_body_s[HDR_DP_BIT]         = parity64(beat_q);
    end

    assign hdr_s = {parity64({2'b00, hdr_body_s[61:0]}), hdr_body_s[62:0]};

    // Output decode: beats and flags depend only on registered state
    always_comb begin
        bus.o_msg_ready              = 1'b0;
        bus.o_pkt                    = 64'd0;
        bus.o_pkt_valid              = 1'b0;
        bus.o_header_is_valid_on_bus = 1'b0;
        bus.o_data_enable            = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.o_msg_ready = 1'b1;
            end
            ST_HDR: begin
                bus.o_pkt                    = hdr_s;
                bus.o_pkt_valid              = 1'b1;
                bus.o_header_is_valid_on_bus = 1'b1;
            end
            ST_DATA: begin
                bus.o_pkt         = beat_q;
                bus.o_pkt_valid   = 1'b1;
                bus.o_data_enable = 1'b1;
            end
            default: begin
                bus.o_msg_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sb_data_encoder.sv
// Self-checking bench for sb_data_encoder: directed cases, a reset in the
// middle of a message, loopback over every payload-carrying code/subcode and
// randomized traffic with random back-pressure, all against a behavioural model.
module tb_sb_data_encoder;

    logic i_clk;
    logic i_rst_n;
    int   n_checks;
    int   n_pass;

    sb_data_encoder_if bus ();

    sb_data_encoder dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Single comparison point for every check in the bench
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic bit m_has_data(input logic [7:0] code, input logic [7:0] sub);
        int n;
        n = int'(sub) % 16;
        if (code == 8'h85) return (n == 1) || (n == 5) || (n == 7) || (n == 10);
        if (code == 8'h81 || code == 8'h8A) return (n == 3) || (n == 11);
        if (code == 8'hA5) return n == 0;
        if (code == 8'hAA) return (n == 0) || (n == 15);
        return 1'b0;
    endfunction

    function automatic logic [63:0] m_beat(input logic [7:0] code, input logic [7:0] sub, input logic [15:0] d);
        logic [63:0] b;
        if (!m_has_data(code, sub)) return 64'd0;
        if (code == 8'h85) begin
            b = 64'(d[0]) + (64'(d[2:1]) << 6) + (64'(d[3]) << 11) + (64'(d[4]) << 59);
        end else if (code == 8'h81 || code == 8'h8A || (int'(sub) % 16) == 15) begin
            b = 64'(d);
        end else begin
            b = 64'(d) % 64'd2048;
        end
        return b;
    endfunction

    function automatic logic [63:0] m_header(input logic [7:0] code, input logic [7:0] sub,
                                             input logic [15:0] info, input logic [15:0] d);
        logic [63:0] h;
        logic [63:0] opc;
        opc = m_has_data(code, sub) ? 64'd27 : 64'd18;
        h = opc + (64'(code) << 14) + (64'd1 << 29) + (64'(sub) << 32)
            + (64'(info) << 40) + (64'd5 << 56);
        h = h + (64'(^m_beat(code, sub, d)) << 62);
        h = h + (64'(^h[61:0]) << 63);
        return h;
    endfunction

    // Receive-side view: payload recovered from a data beat
    function automatic logic [15:0] m_unpack(input logic [7:0] code, input logic [7:0] sub, input logic [63:0] b);
        if (code == 8'h85) return {11'd0, b[59], b[11], b[7:6], b[0]};
        if (code == 8'h81 || code == 8'h8A || (int'(sub) % 16) == 15) return b[15:0];
        return {5'd0, b[10:0]};
    endfunction

    function automatic logic [15:0] m_payload(input logic [7:0] code, input logic [7:0] sub, input logic [15:0] d);
        if (code == 8'h85) return d & 16'h001F;
        if (code == 8'h81 || code == 8'h8A || (int'(sub) % 16) == 15) return d;
        return d & 16'h07FF;
    endfunction

    // ---------------- stimulus ----------------
    // Called at posedge+1 in IDLE; returns at posedge+1 back in IDLE
    task automatic send_msg(input logic [7:0] code, input logic [7:0] sub, input logic [15:0] info,
                            input logic [15:0] d, input int hstall, input int dstall,
                            input bit use_lit, input logic [63:0] lit_beat);
        logic [63:0] eh;
        logic [63:0] eb;
        bit          hd;
        hd = m_has_data(code, sub);
        eb = m_beat(code, sub, d);
        eh = m_header(code, sub, info, d);

        check_eq("idle_ready", 64'(bus.o_msg_ready), 64'd1);
        check_eq("idle_valid", 64'(bus.o_pkt_valid), 64'd0);
        bus.i_msg_valid  = 1'b1;
        bus.i_msgcode    = code;
        bus.i_msgsubcode = sub;
        bus.i_msginfo    = info;
        bus.i_data       = d;
        bus.i_pkt_ready  = (hstall == 0);
        @(posedge i_clk); #1;

        // Busy: a competing request must be ignored
        bus.i_msg_valid  = 1'($urandom_range(0, 1));
        bus.i_msgcode    = 8'($urandom);
        bus.i_msgsubcode = 8'($urandom);
        bus.i_msginfo    = 16'($urandom);
        bus.i_data       = 16'($urandom);
        check_eq("hdr_pkt", bus.o_pkt, eh);
        check_eq("hdr_flag", {62'd0, bus.o_pkt_valid, bus.o_header_is_valid_on_bus}, 64'd3);
        check_eq("hdr_no_den", 64'(bus.o_data_enable), 64'd0);
        check_eq("hdr_busy", 64'(bus.o_msg_ready), 64'd0);
        for (int i = 0; i < hstall; i++) begin
            @(posedge i_clk); #1;
            check_eq("hdr_hold", bus.o_pkt, eh);
            check_eq("hdr_hold_flag", 64'(bus.o_header_is_valid_on_bus), 64'd1);
        end
        bus.i_pkt_ready = 1'b1;
        @(posedge i_clk); #1;

        if (hd) begin
            bus.i_pkt_ready = (dstall == 0);
            check_eq("data_pkt", bus.o_pkt, eb);
            check_eq("data_flag", {62'd0, bus.o_pkt_valid, bus.o_data_enable}, 64'd3);
            check_eq("data_no_hdr", 64'(bus.o_header_is_valid_on_bus), 64'd0);
            check_eq("loopback", 64'(m_unpack(code, sub, bus.o_pkt)), 64'(m_payload(code, sub, d)));
            if (use_lit) check_eq("data_lit", bus.o_pkt, lit_beat);
            for (int i = 0; i < dstall; i++) begin
                @(posedge i_clk); #1;
                check_eq("data_hold", bus.o_pkt, eb);
            end
            bus.i_pkt_ready = 1'b1;
            @(posedge i_clk); #1;
        end

        bus.i_msg_valid = 1'b0;
        bus.i_pkt_ready = 1'($urandom_range(0, 1));
        check_eq("done_ready", 64'(bus.o_msg_ready), 64'd1);
        check_eq("done_idle", {61'd0, bus.o_pkt_valid, bus.o_header_is_valid_on_bus, bus.o_data_enable}, 64'd0);
        check_eq("done_pkt", bus.o_pkt, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] codes [7];
    logic [7:0] lb_code [11];
    logic [3:0] lb_sub  [11];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        bus.i_msg_valid  = 1'b0;
        bus.i_msgcode    = 8'd0;
        bus.i_msgsubcode = 8'd0;
        bus.i_msginfo    = 16'd0;
        bus.i_data       = 16'd0;
        bus.i_pkt_ready  = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check_eq("rst_ready", 64'(bus.o_msg_ready), 64'd1);
        check_eq("rst_pkt", bus.o_pkt, 64'd0);
        check_eq("rst_flags", {61'd0, bus.o_pkt_valid, bus.o_header_is_valid_on_bus, bus.o_data_enable}, 64'd0);
        @(posedge i_clk); @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Directed cases with literal data beats
        send_msg(8'h85, 8'h01, 16'h1234, 16'h001F, 0, 0, 1'b1, 64'h0800_0000_0000_08C1);
        check_eq("dp_85", 64'(m_header(8'h85, 8'h01, 16'h1234, 16'h001F) >> 62) % 64'd2, 64'd1);
        send_msg(8'h81, 8'h03, 16'h0000, 16'hA5C3, 0, 0, 1'b1, 64'h0000_0000_0000_A5C3);
        send_msg(8'hA5, 8'h00, 16'hBEEF, 16'hFFFF, 0, 0, 1'b1, 64'h0000_0000_0000_07FF);
        send_msg(8'hAA, 8'h0F, 16'h0001, 16'h1234, 0, 0, 1'b1, 64'h0000_0000_0000_1234);
        send_msg(8'h95, 8'h00, 16'h5555, 16'hFFFF, 0, 0, 1'b0, 64'd0);
        // Long header stall, then data stall
        send_msg(8'h8A, 8'h0B, 16'hC001, 16'h8001, 5, 3, 1'b1, 64'h0000_0000_0000_8001);

        // Reset asserted while the data beat is on the bus
        bus.i_msg_valid  = 1'b1;
        bus.i_msgcode    = 8'h85;
        bus.i_msgsubcode = 8'h0A;
        bus.i_msginfo    = 16'hFFFF;
        bus.i_data       = 16'hFFFF;
        bus.i_pkt_ready  = 1'b1;
        @(posedge i_clk); #1;
        bus.i_msg_valid = 1'b0;
        @(posedge i_clk); #1;
        check_eq("pre_rst_den", 64'(bus.o_data_enable), 64'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(bus.o_pkt_valid), 64'd0);
        check_eq("mid_rst_pkt", bus.o_pkt, 64'd0);
        check_eq("mid_rst_ready", 64'(bus.o_msg_ready), 64'd1);
        check_eq("mid_rst_den", 64'(bus.o_data_enable), 64'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        check_eq("post_rst_idle", 64'(bus.o_pkt_valid), 64'd0);
        send_msg(8'hAA, 8'h30, 16'h7E7E, 16'hF00D, 1, 1, 1'b0, 64'd0);

        // Loopback over every payload-carrying code/subcode
        lb_code = '{8'h85, 8'h85, 8'h85, 8'h85, 8'h81, 8'h81, 8'h8A, 8'h8A, 8'hA5, 8'hAA, 8'hAA};
        lb_sub  = '{4'h1, 4'h5, 4'h7, 4'hA, 4'h3, 4'hB, 4'h3, 4'hB, 4'h0, 4'h0, 4'hF};
        for (int i = 0; i < 11; i++) begin
            send_msg(lb_code[i], {4'($urandom), lb_sub[i]}, 16'($urandom), 16'($urandom),
                     0, 0, 1'b0, 64'd0);
        end

        // Randomized traffic with random back-pressure
        codes = '{8'h85, 8'h81, 8'h8A, 8'hA5, 8'hAA, 8'h95, 8'h00};
        for (int i = 0; i < 40; i++) begin
            logic [7:0] c;
            c = codes[$urandom_range(0, 6)];
            if (c == 8'h00) c = 8'($urandom);
            send_msg(c, 8'($urandom), 16'($urandom), 16'($urandom),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0, 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
